// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches 32-bit words over a rd/valid handshake and holds each on IR for EXEC_CYCLES
// Ports: clk/clr (sync active-low reset), run (fetch enable), mem_rd/mem_addr/mem_rdata/mem_valid (instruction memory),
//        branch_en/branch_target (taken branch), IR/wren (to control unit), pc, halted
module instruction_fetch_unit #(
  parameter int         ADDR_W      = 8,
  parameter int         EXEC_CYCLES = 2,
  parameter logic [4:0] HALT_OP     = 5'b11111
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       IR,
  output logic              wren,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [31:0] r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic r_wren;
  logic w_ack, w_last;
  logic [4:0] w_next_op;
  assign w_ack = r_state == FETCH && mem_valid;
  assign w_last = r_state == EXEC && r_cnt == 4'd0;
  // opcode that will sit on IR after this edge; decides wren for the coming cycle
  assign w_next_op = w_ack ? mem_rdata[31:27] : r_ir[31:27];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = run ? FETCH : IDLE;
      FETCH:   w_next = !mem_valid ? FETCH : (mem_rdata[31:27] == HALT_OP ? HALT : EXEC);
      EXEC:    w_next = r_cnt != 4'd0 ? EXEC : (run ? FETCH : IDLE);
      default: w_next = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_pc <= '0;
      r_ir <= '0;
      r_cnt <= '0;
      r_wren <= 1'b0;
    end else begin
      if (w_ack) r_ir <= mem_rdata;
      if (w_ack) r_cnt <= 4'(EXEC_CYCLES - 1);
      else if (r_state == EXEC && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_last) r_pc <= branch_en ? branch_target : r_pc + 1'b1;
      r_wren <= w_next == EXEC && w_next_op != 5'd0;
    end
  end
  assign mem_rd = r_state == FETCH;
  assign mem_addr = r_pc;
  assign pc = r_pc;
  assign IR = r_ir;
  assign wren = r_wren;
  assign halted = r_state == HALT;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch, wait states, branch, wrap, NOP, halt and reset
module tb_instruction_fetch_unit;
  logic clk = 1'b0, clr, run, mem_rd, mem_valid, branch_en, wren, halted;
  logic [7:0] mem_addr, branch_target, pc;
  logic [31:0] mem_rdata, IR;
  logic [31:0] mem [256];
  int wait_states, wcnt, vectors, errs;
  always #5 clk = ~clk;
  instruction_fetch_unit dut (
    .clk(clk), .clr(clr), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .branch_en(branch_en),
    .branch_target(branch_target), .IR(IR), .wren(wren), .pc(pc), .halted(halted)
  );
  assign mem_rdata = mem[mem_addr];
  assign mem_valid = mem_rd && (wcnt == wait_states);
  always @(posedge clk) wcnt <= (mem_rd && !mem_valid) ? wcnt + 1 : 0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    vectors = 0; errs = 0; wcnt = 0; wait_states = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h8080008D; mem[1] = 32'h81000029; mem[2] = 32'h12345678;
    mem[3] = 32'h20000001; mem[4] = 32'h20000002; mem[8'h40] = 32'h20000003; mem[8'hFF] = 32'h20000004;
    clr = 0; run = 0; branch_en = 0; branch_target = 8'h00;
    step(); step();
    chk("rst_pc", {24'h0, pc}, 0); chk("rst_ir", IR, 0); chk("rst_wren", {31'h0, wren}, 0);
    chk("rst_rd", {31'h0, mem_rd}, 0); chk("rst_halt", {31'h0, halted}, 0);
    clr = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_rd", {31'h0, mem_rd}, 0); chk("idle_wren", {31'h0, wren}, 0);
    end
    run = 1;
    step(); chk("f0_rd", {31'h0, mem_rd}, 1); chk("f0_addr", {24'h0, mem_addr}, 0);
    step(); chk("e0_ir", IR, 32'h8080008D); chk("e0_wren", {31'h0, wren}, 1); chk("e0_rd", {31'h0, mem_rd}, 0);
    step(); chk("e0b_wren", {31'h0, wren}, 1); chk("e0b_pc", {24'h0, pc}, 0);
    step(); chk("f1_wren", {31'h0, wren}, 0); chk("f1_pc", {24'h0, pc}, 1); chk("f1_rd", {31'h0, mem_rd}, 1);
    chk("f1_ir_hold", IR, 32'h8080008D);
    step(); chk("e1_ir", IR, 32'h81000029); chk("e1_wren", {31'h0, wren}, 1);
    step(); step(); chk("f2_pc", {24'h0, pc}, 2); chk("f2_addr", {24'h0, mem_addr}, 2);
    wait_states = 3;
    step(); chk("w1_rd", {31'h0, mem_rd}, 1); chk("w1_ir", IR, 32'h81000029);
    run = 0;
    step(); chk("w2_rd", {31'h0, mem_rd}, 1); chk("w2_addr", {24'h0, mem_addr}, 2);
    step(); chk("w3_rd", {31'h0, mem_rd}, 1); chk("w3_ir", IR, 32'h81000029);
    step(); chk("w_ir", IR, 32'h12345678); chk("w_wren", {31'h0, wren}, 1); chk("w_rd", {31'h0, mem_rd}, 0);
    step(); step(); chk("w_idle_pc", {24'h0, pc}, 3); chk("w_idle_wren", {31'h0, wren}, 0);
    step(); chk("w_idle_rd", {31'h0, mem_rd}, 0);
    wait_states = 0; run = 1;
    step(); chk("b_f_addr", {24'h0, mem_addr}, 3);
    step(); chk("b_ir", IR, 32'h20000001);
    branch_en = 1; branch_target = 8'h40;
    step(); branch_en = 0;
    step(); chk("b_ignored_pc", {24'h0, pc}, 4);
    step(); step(); branch_en = 1;
    step(); branch_en = 0;
    chk("b_taken_addr", {24'h0, mem_addr}, 32'h40); chk("b_taken_rd", {31'h0, mem_rd}, 1);
    step(); chk("b_ir40", IR, 32'h20000003);
    step(); branch_en = 1; branch_target = 8'hFF;
    step(); branch_en = 0; chk("wr_pcff", {24'h0, pc}, 32'hFF);
    step(); step();
    mem[0] = 32'h0;
    step(); chk("wr_pc0", {24'h0, pc}, 0); chk("wr_rd", {31'h0, mem_rd}, 1);
    mem[1] = 32'hF8000000;
    step(); chk("nop_ir", IR, 0); chk("nop_wren", {31'h0, wren}, 0);
    step(); chk("nop_wren2", {31'h0, wren}, 0);
    step(); chk("nop_pc", {24'h0, pc}, 1);
    step(); chk("h_ir", IR, 32'hF8000000);
    for (int i = 0; i < 10; i++) begin
      chk("h_halted", {31'h0, halted}, 1); chk("h_rd", {31'h0, mem_rd}, 0);
      chk("h_wren", {31'h0, wren}, 0); chk("h_pc", {24'h0, pc}, 1);
      step();
    end
    clr = 0;
    step(); chk("hr_halted", {31'h0, halted}, 0); chk("hr_ir", IR, 0); chk("hr_pc", {24'h0, pc}, 0);
    mem[0] = 32'h20000005; mem[1] = 32'h20000006; clr = 1;
    step(); step(); step(); step(); chk("m_pc1", {24'h0, pc}, 1);
    step(); chk("m_wren", {31'h0, wren}, 1);
    clr = 0;
    step(); chk("me_wren", {31'h0, wren}, 0); chk("me_pc", {24'h0, pc}, 0); chk("me_ir", IR, 0);
    chk("me_rd", {31'h0, mem_rd}, 0);
    clr = 1; wait_states = 3;
    step(); step(); chk("mf_rd", {31'h0, mem_rd}, 1);
    clr = 0;
    step(); chk("mf_rd0", {31'h0, mem_rd}, 0); chk("mf_wren", {31'h0, wren}, 0);
    chk("mf_pc", {24'h0, pc}, 0); chk("mf_ir", IR, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit.
- Owns the program counter and reads 32-bit instruction words from instruction memory over a request/valid handshake.
- Drives IR and wren into the control unit, holding each instruction stable for a fixed number of execute cycles.
- Handles taken branches by loading a target address, and halts on a halt opcode.

Parameters:
- ADDR_W, 8, program counter and memory address width; PC wraps modulo 2^ADDR_W.
- EXEC_CYCLES, 2, clock cycles each instruction is held on IR with wren asserted; legal range 1 to 15.
- HALT_OP, 5'b11111, opcode in IR[31:27] that stops fetching.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  reset; synchronous and active-low (clr=0 on a rising clk edge resets the block).
- run  in  1  fetch enable; level sensitive.
- mem_rd  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; always equals pc.
- mem_rdata  in  32  instruction word; valid only when mem_valid=1.
- mem_valid  in  1  memory acknowledge; may assert in the same cycle as mem_rd.
- branch_en  in  1  taken-branch request from the control unit.
- branch_target  in  ADDR_W  next PC when branch_en is sampled high.
- IR  out  32  instruction register to the control unit.
- wren  out  1  register-file write enable to the control unit.
- pc  out  ADDR_W  current program counter.
- halted  out  1  high once HALT_OP has been fetched.

Behaviour:
- Reset (clr=0 at a clk edge):
  - state=IDLE, pc=0, IR=0, wren=0, mem_rd=0, halted=0, exec counter=0.
  - Reset has priority over everything and aborts any state, including a fetch in flight.
- IDLE:
  - mem_rd=0, wren=0.
  - If run=1, go to FETCH on the next edge.
- FETCH:
  - mem_rd=1, mem_addr=pc.
  - Waits indefinitely for mem_valid; no timeout.
  - On an edge with mem_valid=1: IR<=mem_rdata and mem_rd drops.
    - If mem_rdata[31:27]==HALT_OP: go to HALT.
    - Otherwise: go to EXEC, counter<=EXEC_CYCLES-1.
  - Deasserting run during FETCH does not abandon the read; the fetch completes normally.
- EXEC:
  - IR is held constant.
  - wren=1 for every EXEC cycle, except wren=0 when IR[31:27]==5'b00000 (NOP).
  - Counter decrements each cycle.
  - In the cycle where the counter is 0 (the last EXEC cycle):
    - branch_en is sampled; pc<=branch_target if branch_en=1, else pc<=pc+1.
    - All-ones pc+1 wraps to 0.
    - Next state is FETCH if run=1, else IDLE.
  - branch_en is ignored in all other cycles and states.
- HALT:
  - halted=1, mem_rd=0, wren=0.
  - IR keeps the halt word; pc is not incremented.
  - Only reset leaves HALT; run has no effect.
- wren is registered: it rises on the edge that enters EXEC and falls on the edge that leaves EXEC.
- Latency, with run rising before edge 0:
  - edge 0: enter FETCH.
  - With zero-wait memory (mem_valid=1 in the first FETCH cycle): IR valid and wren=1 after edge 1.
  - Instruction period = 1 + EXEC_CYCLES + memory wait cycles.
- IR changes only on a FETCH-completing edge or on reset. The control unit may sample IR at any EXEC cycle.
- No output is X after the first reset edge.

Test Plan:
- Reset and boot: clr=0 for 2 edges, then clr=1 with run=0 → pc=0, IR=0, wren=0, mem_rd=0, halted=0; state stays IDLE for 5 cycles.
- Sequential fetch: memory[0]=32'h8080008D, memory[1]=32'h81000029, zero-wait, run=1 → IR=32'h8080008D with wren=1 for exactly 2 cycles, then IR=32'h81000029; pc goes 0→1→2; mem_rd pulses once per instruction.
- Wait states: mem_valid delayed 3 cycles after mem_rd → mem_rd held 4 cycles, mem_addr stable, IR unchanged until the acknowledge edge; run dropped mid-wait → fetch still completes, then IDLE after EXEC.
- Branch and wrap: branch_en=1 with branch_target=8'h40 in the last EXEC cycle → next mem_addr=8'h40; branch_en=1 in the first EXEC cycle only → ignored, pc+1. Separately, at pc=8'hFF with no branch → next pc=8'h00.
- NOP and halt: fetch of 32'h00000000 → EXEC with wren=0, pc still increments. Fetch of 32'hF8000000 → halted=1, wren=0, mem_rd=0 held for 10 cycles despite run=1; clr=0 → returns to reset values.
- Reset mid-operation: clr=0 during EXEC with wren=1, and separately during FETCH with mem_rd=1 → both outputs 0 after that edge, pc=0, IR=0.
